// File: rtl/mtm_alu.sv
// mtm_alu: serial 32-bit ALU.
// A request is 8 DATA words (B then A, MSB byte first) followed by one CTL
// word {0, OP, CRC4}. The response is either 4 DATA words of C plus a CTL
// word {0, FLAGS, CRC3}, or a single CTL error word.
// Words are 11 bits, MSB first: start 0, type, 8 payload bits, stop 1.
//
// Ports:
//   clk   - single clock, all state changes on posedge
//   rst_n - asynchronous active-low reset
//   sin   - serial request line, idle high
//   sout  - serial response line, idle high
//
// Build option: define MTM_ALU_CRC_CHECK_EN to check the request CRC4.
// When it is undefined the CRC4 field is ignored.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for the start bit of the first word of a request
// RX_DATA  | receiving DATA words, or waiting between words
// RX_CTL   | receiving the remainder of a CTL word
// CALC     | evaluating the operation and errors, loading the response
// TX       | shifting the response out on sout
// ERR_SYNC | after a bad stop bit, waiting for 11 consecutive high bits
module mtm_alu (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic sout
);

  typedef enum logic [2:0] {IDLE, RX_DATA, RX_CTL, CALC, TX, ERR_SYNC} state_t;

  state_t      state_q, state_d;

  logic [3:0]  bits_left;   // bits still to sample in the current word, 0 = between words
  logic [7:0]  rx_shift;
  logic [63:0] data_sr;     // holds {B, A} once eight DATA words are in
  logic [3:0]  word_cnt;    // DATA words received, saturates at 15
  logic        err_d;       // a stop bit was 0 during this request
  logic [3:0]  sync_cnt;
  logic [54:0] tx_sr;
  logic [5:0]  tx_cnt;

  logic [31:0] b_op, a_op, c_res;
  logic [2:0]  op;
  logic [32:0] sum;
  logic        carry, ovf, eo;
  logic [3:0]  flags;
  logic [2:0]  crc3;
  logic        ed, ec;
  logic        e_d, e_c, e_o;
  logic [6:0]  err_fields;
  logic [7:0]  err_payload;

  function automatic logic [2:0] crc3_of(input logic [36:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 36; i >= 0; i--)
      r = {r[1:0], 1'b0} ^ ((r[2] ^ m[i]) ? 3'b011 : 3'b000);
    return r;
  endfunction

`ifdef MTM_ALU_CRC_CHECK_EN
  function automatic logic [3:0] crc4_of(input logic [67:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 67; i >= 0; i--)
      r = {r[2:0], 1'b0} ^ ((r[3] ^ m[i]) ? 4'b0011 : 4'b0000);
    return r;
  endfunction

  assign ec = (crc4_of({b_op, a_op, 1'b1, op}) != rx_shift[3:0]);
`else
  assign ec = 1'b0;
`endif

  assign b_op = data_sr[63:32];
  assign a_op = data_sr[31:0];
  assign op   = rx_shift[6:4];

  always_comb begin
    sum   = 33'd0;
    c_res = 32'd0;
    carry = 1'b0;
    ovf   = 1'b0;
    eo    = 1'b0;
    case (op)
      3'b000: c_res = b_op & a_op;
      3'b001: c_res = b_op | a_op;
      3'b100: begin
        sum   = {1'b0, b_op} + {1'b0, a_op};
        c_res = sum[31:0];
        carry = sum[32];
        ovf   = (b_op[31] == a_op[31]) && (c_res[31] != b_op[31]);
      end
      3'b101: begin
        // bit 32 of the widened difference is the borrow (B < A unsigned)
        sum   = {1'b0, b_op} - {1'b0, a_op};
        c_res = sum[31:0];
        carry = sum[32];
        ovf   = (b_op[31] != a_op[31]) && (c_res[31] != b_op[31]);
      end
      default: eo = 1'b1;
    endcase
  end

  assign flags = {carry, ovf, (c_res == 32'd0), c_res[31]};
  assign crc3  = crc3_of({c_res, 1'b0, flags});

  assign ed  = err_d | (word_cnt != 4'd8);
  // only the highest-priority error is reported
  assign e_d = ed;
  assign e_c = ec & ~ed;
  assign e_o = eo & ~ed & ~ec;
  assign err_fields  = {1'b1, e_d, e_c, e_o, e_d, e_c, e_o};
  assign err_payload = {err_fields, ^err_fields};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!sin) state_d = RX_DATA;
      RX_DATA: begin
        if (bits_left == 4'd10 && sin) state_d = RX_CTL;
        else if (bits_left == 4'd1)    state_d = sin ? RX_DATA : ERR_SYNC;
      end
      RX_CTL:   if (bits_left == 4'd1) state_d = sin ? CALC : ERR_SYNC;
      CALC:     state_d = TX;
      TX:       if (tx_cnt == 6'd0) state_d = IDLE;
      ERR_SYNC: if (sin && sync_cnt == 4'd1) state_d = CALC;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_left <= 4'd0;
      rx_shift  <= 8'd0;
      data_sr   <= 64'd0;
      word_cnt  <= 4'd0;
      err_d     <= 1'b0;
      sync_cnt  <= 4'd0;
      tx_sr     <= '1;
      tx_cnt    <= 6'd0;
      sout      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            bits_left <= 4'd10;
            word_cnt  <= 4'd0;
            err_d     <= 1'b0;
          end
        end
        RX_DATA, RX_CTL: begin
          if (bits_left == 4'd0) begin
            if (!sin) bits_left <= 4'd10;
          end else begin
            bits_left <= bits_left - 4'd1;
            if (bits_left <= 4'd9 && bits_left >= 4'd2)
              rx_shift <= {rx_shift[6:0], sin};
            if (bits_left == 4'd1) begin
              if (!sin) begin
                err_d    <= 1'b1;
                sync_cnt <= 4'd11;
              end else if (state_q == RX_DATA) begin
                data_sr <= {data_sr[55:0], rx_shift};
                if (word_cnt != 4'hF) word_cnt <= word_cnt + 4'd1;
              end
            end
          end
        end
        ERR_SYNC: begin
          if (!sin) sync_cnt <= 4'd11;
          else      sync_cnt <= sync_cnt - 4'd1;
        end
        CALC: begin
          if (ed | ec | eo) begin
            tx_sr  <= {2'b01, err_payload, 1'b1, 44'hFFF_FFFF_FFFF};
            tx_cnt <= 6'd11;
          end else begin
            tx_sr  <= {2'b00, c_res[31:24], 1'b1,
                       2'b00, c_res[23:16], 1'b1,
                       2'b00, c_res[15:8],  1'b1,
                       2'b00, c_res[7:0],   1'b1,
                       2'b01, 1'b0, flags, crc3, 1'b1};
            tx_cnt <= 6'd55;
          end
        end
        TX: begin
          if (tx_cnt != 6'd0) begin
            sout   <= tx_sr[54];
            tx_sr  <= {tx_sr[53:0], 1'b1};
            tx_cnt <= tx_cnt - 6'd1;
          end else begin
            sout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu.sv
module tb_mtm_alu;

  logic clk;
  logic rst_n;
  logic sin;
  logic sout;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int          nd;
    logic [31:0] c;
    logic [7:0]  ctl;
  } resp_t;

  resp_t sb[$];

  mtm_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sin   (sin),
    .sout  (sout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // reference CRCs by polynomial long division
  function automatic logic [3:0] crc4_ref(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] crc3_ref(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic resp_t model(input logic [31:0] b, input logic [31:0] a,
                                  input logic [2:0] op, input int ndata,
                                  input bit bad_crc, input bit bad_stop);
    resp_t       r;
    logic [31:0] c;
    logic [3:0]  fl;
    longint      sr;
    bit          cy, ov, ed, ec, eo;
    ed = bad_stop || (ndata != 8);
`ifdef MTM_ALU_CRC_CHECK_EN
    ec = bad_crc;
`else
    ec = 1'b0;
`endif
    eo = !(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101);
    r.nd = 0;
    r.c  = 32'd0;
    if (ed || ec || eo) begin
      if (ed)      r.ctl = 8'hC9;
      else if (ec) r.ctl = 8'hA5;
      else         r.ctl = 8'h93;
      return r;
    end
    cy = 1'b0;
    ov = 1'b0;
    sr = 0;
    case (op)
      3'b000: c = b & a;
      3'b001: c = b | a;
      3'b100: begin
        c  = b + a;
        cy = ({32'h0, b} + {32'h0, a}) > 64'h0000_0000_FFFF_FFFF;
        sr = longint'($signed(b)) + longint'($signed(a));
        ov = (sr != longint'($signed(c)));
      end
      default: begin
        c  = b - a;
        cy = (b < a);
        sr = longint'($signed(b)) - longint'($signed(a));
        ov = (sr != longint'($signed(c)));
      end
    endcase
    fl    = {cy, ov, (c == 32'd0), c[31]};
    r.nd  = 4;
    r.c   = c;
    r.ctl = {1'b0, fl, crc3_ref({c, 1'b0, fl})};
    return r;
  endfunction

  task automatic send_word(input bit typ, input logic [7:0] p, input bit stop, input bit rel);
    logic [10:0] bits;
    bits = {1'b0, typ, p, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = bits[i];
      if (i == 10 && rel) rst_n = 1'b1;
    end
  endtask

  task automatic send_req(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                          input int ndata, input bit bad_crc, input bit bad_stop, input bit rel);
    logic [63:0] d;
    logic [3:0]  crc;
    d   = {b, a};
    crc = crc4_ref({b, a, 1'b1, op});
    if (bad_crc) crc = ~crc;
    sb.push_back(model(b, a, op, ndata, bad_crc, bad_stop));
    for (int i = 0; i < ndata; i++) begin
      send_word(1'b0, d[63:56], !(bad_stop && i == ndata - 1), rel && i == 0);
      d = {d[55:0], d[63:56]};
    end
    if (bad_stop) begin
      @(negedge clk);
      sin = 1'b1;
    end else begin
      send_word(1'b1, {1'b0, op, crc}, 1'b1, rel && ndata == 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (15) @(negedge clk);
  endtask

  // response monitor: decodes words from sout and checks them against the scoreboard
  initial begin : monitor
    logic [10:0] w;
    logic [31:0] c;
    int          nd;
    bit          aborted;
    resp_t       e;
    nd = 0;
    c  = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nd = 0;
        c  = 32'd0;
        continue;
      end
      if (sout === 1'b0) begin
        w[10]   = 1'b0;
        aborted = 1'b0;
        for (int i = 9; i >= 0; i--) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          w[i] = sout;
        end
        if (aborted) begin
          nd = 0;
          c  = 32'd0;
          continue;
        end
        if (w[0] !== 1'b1) begin
          vectors++;
          errors++;
          $display("FAIL resp_stop_bit: got %b, required 1", w[0]);
        end
        if (w[9] === 1'b0) begin
          c = {c[23:0], w[8:1]};
          nd++;
        end else begin
          vectors++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got ctl %h after %0d data words, required no response",
                     w[8:1], nd);
          end else begin
            e = sb.pop_front();
            if (nd !== e.nd || c !== e.c || w[8:1] !== e.ctl) begin
              errors++;
              $display("FAIL response: got nd=%0d c=%h ctl=%h, required nd=%0d c=%h ctl=%h",
                       nd, c, w[8:1], e.nd, e.c, e.ctl);
            end
          end
          nd = 0;
          c  = 32'd0;
        end
      end
    end
  end

  task automatic test_reset();
    int zeros;
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (sout !== 1'b1) begin
      errors++;
      $display("FAIL reset_sout: got %b, required 1", sout);
    end
    rst_n = 1'b1;
    zeros = 0;
    repeat (20) begin
      @(negedge clk);
      if (sout !== 1'b1) zeros++;
    end
    vectors++;
    if (zeros !== 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d low bits, required 0", zeros);
    end
  endtask

  task automatic test_latency();
    logic s1, s2, s3;
    send_req(32'h0F0F0F0F, 32'hFFFFFFFF, 3'b000, 8, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk); s1 = sout;
    @(negedge clk); s2 = sout;
    @(negedge clk); s3 = sout;
    vectors++;
    if ({s1, s2, s3} !== 3'b110) begin
      errors++;
      $display("FAIL latency: got sout seq %b%b%b, required 110", s1, s2, s3);
    end
    wait_idle();
  endtask

  task automatic test_arith();
    send_req(32'hFFFFFFFF, 32'h00000001, 3'b100, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h80000000, 32'h00000001, 3'b101, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h12340000, 32'h00005678, 3'b001, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h7FFFFFFF, 32'h00000001, 3'b100, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h00000005, 32'h00000005, 3'b101, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_random();
    logic [2:0] ops [4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;
    for (int i = 0; i < 6; i++) begin
      send_req($urandom, $urandom, ops[$urandom_range(0, 3)], 8, 1'b0, 1'b0, 1'b0);
      wait_idle();
    end
  endtask

  task automatic test_errors();
    send_req(32'h11111111, 32'h22222222, 3'b010, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h11111111, 32'h22222222, 3'b000, 4, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h11111111, 32'h22222222, 3'b000, 0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h11111111, 32'h22222222, 3'b000, 9, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'hDEADBEEF, 32'h01234567, 3'b100, 8, 1'b1, 1'b0, 1'b0);
    wait_idle();
    send_req(32'hDEADBEEF, 32'h01234567, 3'b111, 8, 1'b1, 1'b0, 1'b0);
    wait_idle();
    send_req(32'hCAFEF00D, 32'h0, 3'b000, 2, 1'b0, 1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic test_ignore_during_tx();
    send_req(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, 8, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    sin = 1'b0;
    repeat (20) @(negedge clk);
    sin = 1'b1;
    wait_idle();
    send_req(32'h00000003, 32'h00000004, 3'b101, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n, zeros;
    send_req(32'h0F0F0F0F, 32'hFFFFFFFF, 3'b000, 8, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (sout !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sout !== 1'b0) begin
      errors++;
      $display("FAIL resp_start_timeout: got sout %b, required 0", sout);
    end
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (sout !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_sout: got %b, required 1", sout);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    zeros = 0;
    repeat (70) begin
      @(negedge clk);
      if (sout !== 1'b1) zeros++;
    end
    vectors++;
    if (zeros !== 0) begin
      errors++;
      $display("FAIL reset_mid_resume: got %0d low bits, required 0", zeros);
    end
    // partial request then reset: the next request must start from a clean word count
    for (int i = 0; i < 3; i++) send_word(1'b0, 8'h55, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_req(32'hFFFFFFFF, 32'h00000001, 3'b100, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_release_start();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    send_req(32'h80000000, 32'h00000001, 3'b101, 8, 1'b0, 1'b0, 1'b1);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    send_req(32'h00000010, 32'h00000020, 3'b100, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'h00000010, 32'h00000020, 3'b101, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
    send_req(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 8, 1'b0, 1'b0, 1'b0);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    test_reset();
    test_latency();
    test_arith();
    test_errors();
    test_random();
    test_ignore_during_tx();
    test_reset_mid();
    test_release_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
